dvs_event_unpacker: RTL and testbench
=====================================

DVS_EVENT_UNPACKER -- requirements
Module: dvs_event_unpacker

Interface
REQ-001 SHALL have parameter X_BITS, default 7, event x-coordinate width.
REQ-002 SHALL have parameter Y_BITS, default 7, event y-coordinate width.
REQ-003 SHALL have parameter TS_BITS, default 16, event timestamp width.
REQ-004 SHALL have parameter SYNC_BYTE, default 8'hA5, packet header byte.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000, maximum clk cycles between bytes inside a packet.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 byte_valid  input  1  inbound byte strobe, one byte per cycle when high.
REQ-009 byte_data  input  8  inbound byte.
REQ-010 event_valid  output  1  one-cycle pulse, event fields valid.
REQ-011 event_x  output  X_BITS  x coordinate.
REQ-012 event_y  output  Y_BITS  y coordinate.
REQ-013 event_polarity  output  1  1=ON, 0=OFF.
REQ-014 event_ts  output  TS_BITS  timestamp.
REQ-015 pkt_count  output  16  completed packets, wraps at 16'hFFFF->0.
REQ-016 err_count  output  8  dropped packets, saturates at 8'hFF.

Function
REQ-017 Packet SHALL be 5 bytes: B0=SYNC_BYTE; B1={pol, x[6:0]}; B2={0, y[6:0]}; B3=ts[15:8]; B4=ts[7:0].
REQ-018 FSM states SHALL be HUNT, GET_XP, GET_Y, GET_TSH, GET_TSL; reset state HUNT.
REQ-019 HUNT: byte==SYNC_BYTE -> GET_XP; any other byte discarded, no counter change.
REQ-020 GET_XP -> GET_Y, GET_Y -> GET_TSH, GET_TSH -> GET_TSL on each accepted byte; GET_TSL -> HUNT on accepted byte.
REQ-021 In GET_Y, byte_data[7]==1 SHALL be framing error: packet dropped, err_count +1 (saturating), -> HUNT.
REQ-022 SYNC_BYTE value received in GET_XP..GET_TSL SHALL be treated as data (no resync).
REQ-023 Idle counter SHALL reset on every accepted byte and increment each cycle without byte_valid while not in HUNT.
REQ-024 Idle counter reaching TIMEOUT_CYCLES SHALL drop packet, err_count +1 (saturating), -> HUNT that cycle; counter inactive in HUNT.
REQ-025 event_valid SHALL pulse high exactly one cycle, the cycle after B4 accepted; pkt_count increments same cycle.
REQ-026 event_x/y/polarity/ts SHALL update only with event_valid and hold until next event.
REQ-027 Partial fields SHALL be captured in shadow registers; outputs never show partial-packet data.
REQ-028 Back-to-back packets (B0 of next packet the cycle after B4) SHALL be accepted with no lost bytes.
REQ-029 Byte arriving on the timeout cycle SHALL take precedence: accepted, no timeout.
REQ-030 No backpressure; every byte_valid cycle consumes one byte.

Reset
REQ-031 rst SHALL force state HUNT, idle counter 0, event_valid 0, event_x/y/polarity/ts 0, pkt_count 0, err_count 0.
REQ-032 rst mid-packet SHALL discard partial packet without error count; rst takes priority over byte_valid.

Verification
REQ-033 Bytes A5,85,12,03,E8 -> one cycle after last byte: event_valid=1, x=5, pol=1, y=18, ts=1000, pkt_count=1.
REQ-034 Bytes 00,7F,A5,0A,0B,00,01 -> one event x=10, pol=0, y=11, ts=1; err_count=0.
REQ-035 A5,01,80 (y bit7 set) -> no event, err_count=1; next valid packet decoded correctly.
REQ-036 A5,01 then TIMEOUT_CYCLES idle cycles -> err_count=1, state HUNT; then A5,01,02,03,04 -> event x=1,y=2,ts=16'h0304.
REQ-037 Two packets back-to-back, 10 consecutive byte_valid cycles -> two event_valid pulses 5 cycles apart, pkt_count=2.
REQ-038 260 framing errors -> err_count=255; rst asserted after A5,01 -> all outputs 0, following packet decoded.

Source files
------------

// File: rtl/dvs_event_unpacker.sv
// Unpacks 5-byte DVS event packets (sync, pol/x, y, ts_hi, ts_lo) from a byte stream.
// A gap of TIMEOUT_CYCLES idle cycles inside a packet drops it, and so does a set bit 7 in the y byte.
module dvs_event_unpacker #(
   parameter int          X_BITS         = 7,
   parameter int          Y_BITS         = 7,
   parameter int          TS_BITS        = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               event_valid,
   output logic [X_BITS-1:0]  event_x,
   output logic [Y_BITS-1:0]  event_y,
   output logic               event_polarity,
   output logic [TS_BITS-1:0] event_ts,
   output logic [15:0]        pkt_count,
   output logic [7:0]         err_count
);

   // state   | meaning
   // HUNT    | waiting for SYNC_BYTE, idle timer stopped
   // GET_XP  | expecting {pol, x}
   // GET_Y   | expecting {0, y}; bit 7 set is a framing error
   // GET_TSH | expecting ts[15:8]
   // GET_TSL | expecting ts[7:0]; completes the event
   typedef enum logic [2:0] {HUNT, GET_XP, GET_Y, GET_TSH, GET_TSL} state_t;

   localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [IDLE_W-1:0]    idle_q, idle_d;
   logic [7:0]           xp_q, xp_d;
   logic [6:0]           y_q, y_d;
   logic [7:0]           tsh_q, tsh_d;
   logic                 ev_valid_q, ev_valid_d;
   logic [X_BITS-1:0]    ev_x_q, ev_x_d;
   logic [Y_BITS-1:0]    ev_y_q, ev_y_d;
   logic                 ev_pol_q, ev_pol_d;
   logic [TS_BITS-1:0]   ev_ts_q, ev_ts_d;
   logic [15:0]          pkt_q, pkt_d;
   logic [7:0]           err_q, err_d;
   logic                 drop;

   always_comb begin
      state_d    = state_q;
      idle_d     = idle_q;
      xp_d       = xp_q;
      y_d        = y_q;
      tsh_d      = tsh_q;
      ev_valid_d = 1'b0;
      ev_x_d     = ev_x_q;
      ev_y_d     = ev_y_q;
      ev_pol_d   = ev_pol_q;
      ev_ts_d    = ev_ts_q;
      pkt_d      = pkt_q;
      err_d      = err_q;
      drop       = 1'b0;

      // A byte on the would-be timeout cycle wins, so the timer only acts on idle cycles.
      if (state_q != HUNT && !byte_valid) begin
         if (idle_q == IDLE_LAST) begin
            drop    = 1'b1;
            state_d = HUNT;
            idle_d  = '0;
         end else begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end

      if (byte_valid) begin
         idle_d = '0;
         case (state_q)
            HUNT: begin
               if (byte_data == SYNC_BYTE) state_d = GET_XP;
            end
            GET_XP: begin
               xp_d    = byte_data;
               state_d = GET_Y;
            end
            GET_Y: begin
               if (byte_data[7]) begin
                  drop    = 1'b1;
                  state_d = HUNT;
               end else begin
                  y_d     = byte_data[6:0];
                  state_d = GET_TSH;
               end
            end
            GET_TSH: begin
               tsh_d   = byte_data;
               state_d = GET_TSL;
            end
            GET_TSL: begin
               ev_valid_d = 1'b1;
               ev_x_d     = X_BITS'(xp_q[6:0]);
               ev_pol_d   = xp_q[7];
               ev_y_d     = Y_BITS'(y_q);
               ev_ts_d    = TS_BITS'({tsh_q, byte_data});
               pkt_d      = pkt_q + 16'd1;
               state_d    = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end

      if (drop && err_q != 8'hFF) err_d = err_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= HUNT;
         idle_q     <= '0;
         xp_q       <= '0;
         y_q        <= '0;
         tsh_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_x_q     <= '0;
         ev_y_q     <= '0;
         ev_pol_q   <= 1'b0;
         ev_ts_q    <= '0;
         pkt_q      <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         idle_q     <= idle_d;
         xp_q       <= xp_d;
         y_q        <= y_d;
         tsh_q      <= tsh_d;
         ev_valid_q <= ev_valid_d;
         ev_x_q     <= ev_x_d;
         ev_y_q     <= ev_y_d;
         ev_pol_q   <= ev_pol_d;
         ev_ts_q    <= ev_ts_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
      end
   end

   assign event_valid    = ev_valid_q;
   assign event_x        = ev_x_q;
   assign event_y        = ev_y_q;
   assign event_polarity = ev_pol_q;
   assign event_ts       = ev_ts_q;
   assign pkt_count      = pkt_q;
   assign err_count      = err_q;

endmodule

// File: tb/tb_dvs_event_unpacker.sv
// Scoreboard bench for dvs_event_unpacker: a byte-list packet model predicts events and counters,
// and a negedge monitor compares what the DUT presents.
module tb_dvs_event_unpacker;

   localparam int         T    = 1000;
   localparam logic [7:0] SYNC = 8'hA5;

   logic        clk = 1'b0;
   logic        rst;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        event_valid;
   logic [6:0]  event_x;
   logic [6:0]  event_y;
   logic        event_polarity;
   logic [15:0] event_ts;
   logic [15:0] pkt_count;
   logic [7:0]  err_count;

   dvs_event_unpacker dut (
      .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
      .event_valid(event_valid), .event_x(event_x), .event_y(event_y),
      .event_polarity(event_polarity), .event_ts(event_ts),
      .pkt_count(pkt_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [6:0]  x;
      logic [6:0]  y;
      logic        pol;
      logic [15:0] ts;
   } ev_t;

   ev_t        exp_q[$];
   logic [7:0] pkt_buf[$];
   int         idle_n   = 0;
   int         m_err_n  = 0, m_err_c = 0;
   int         m_pkt_n  = 0, m_pkt_c = 0;
   bit         m_rst_n  = 0, m_rst_c = 0;
   int         cyc      = 0;
   bit         chk_en   = 0;
   int         n_checks = 0;
   int         n_err    = 0;

   logic [6:0]  hold_x = '0, hold_y = '0;
   logic        hold_pol = 1'b0;
   logic [15:0] hold_ts = '0;
   ev_t         e;

   // Model state advanced by the driver becomes "current" at the edge that applies it to the DUT.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      m_err_c <= m_err_n;
      m_pkt_c <= m_pkt_n;
      m_rst_c <= m_rst_n;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_drop();
      pkt_buf.delete();
      idle_n = 0;
      if (m_err_n < 255) m_err_n++;
   endtask

   task automatic model_step(input bit r, input bit v, input logic [7:0] d);
      ev_t ne;
      m_rst_n = r;
      if (r) begin
         pkt_buf.delete();
         idle_n  = 0;
         m_err_n = 0;
         m_pkt_n = 0;
      end else if (v) begin
         idle_n = 0;
         if (pkt_buf.size() != 0 || d == SYNC) pkt_buf.push_back(d);
         if (pkt_buf.size() == 3 && d[7]) begin
            model_drop();
         end else if (pkt_buf.size() == 5) begin
            ne.due = cyc + 1;
            ne.x   = pkt_buf[1][6:0];
            ne.pol = pkt_buf[1][7];
            ne.y   = pkt_buf[2][6:0];
            ne.ts  = 16'(int'(pkt_buf[3]) * 256 + int'(pkt_buf[4]));
            exp_q.push_back(ne);
            m_pkt_n = (m_pkt_n + 1) % 65536;
            pkt_buf.delete();
         end
      end else if (pkt_buf.size() != 0) begin
         idle_n++;
         if (idle_n == T) model_drop();
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_rst_c) begin
            hold_x = '0; hold_y = '0; hold_pol = 1'b0; hold_ts = '0;
         end
         if (exp_q.size() != 0 && exp_q[0].due < cyc && !event_valid) begin
            e = exp_q.pop_front();
            chk("missing_event", 32'(event_valid), 32'd1);
         end
         if (event_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", 32'(event_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("event_cycle", 32'(cyc), 32'(e.due));
               hold_x = e.x; hold_y = e.y; hold_pol = e.pol; hold_ts = e.ts;
            end
         end
         chk("event_x",   32'(event_x),        32'(hold_x));
         chk("event_y",   32'(event_y),        32'(hold_y));
         chk("event_pol", 32'(event_polarity), 32'(hold_pol));
         chk("event_ts",  32'(event_ts),       32'(hold_ts));
         chk("pkt_count", 32'(pkt_count),      32'(m_pkt_c));
         chk("err_count", 32'(err_count),      32'(m_err_c));
      end
   end

   task automatic drive(input bit r, input bit v, input logic [7:0] d);
      rst        = r;
      byte_valid = v;
      byte_data  = d;
      model_step(r, v, d);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      drive(1'b0, 1'b1, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic send_pkt(input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4);
      send(SYNC); send(b1); send(b2); send(b3); send(b4);
   endtask

   initial begin
      rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 8'h00);
      chk_en = 1;
      idle(2);

      send_pkt(8'h85, 8'h12, 8'h03, 8'hE8);
      idle(2);
      send(8'h00); send(8'h7F);
      send_pkt(8'h0A, 8'h0B, 8'h00, 8'h01);
      idle(2);
      send(SYNC); send(8'h01); send(8'h80);
      send_pkt(8'h02, 8'h03, 8'h04, 8'h05);
      idle(2);
      // full timeout, then a clean packet
      send(SYNC); send(8'h01);
      idle(T);
      send_pkt(8'h01, 8'h02, 8'h03, 8'h04);
      // byte arriving on the timeout cycle is kept
      send(SYNC); send(8'h11);
      idle(T - 1);
      send(8'h22); send(8'h33); send(8'h44);
      idle(1);
      // sync value used as data inside a packet, back-to-back
      send_pkt(SYNC, 8'h25, SYNC, SYNC);
      send_pkt(8'hFF, 8'h7F, 8'hFF, 8'hFF);
      idle(2);
      for (int i = 0; i < 260; i++) begin
         send(SYNC); send(8'h01); send(8'h80);
      end
      idle(1);
      send(SYNC); send(8'h01);
      drive(1'b1, 1'b1, 8'h02);
      idle(1);
      send_pkt(8'h83, 8'h04, 8'h12, 8'h34);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            send(SYNC); send(8'($urandom));
            idle(T - 1 + int'($urandom_range(0, 1)));
         end else if ($urandom_range(0, 3) != 0) begin
            send(($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom));
         end else begin
            idle(1);
         end
      end
      idle(3);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
